flash_bus_arbiter: RTL and testbench
====================================

Name: flash_bus_arbiter

Overview:
- Owns the shared parallel-flash bus (fsm_a/fsm_d/cen/oen/wen/advn).
- Arbitrates it between two requesters: the PFL configuration engine and the user flash controller.
- Drives the mux select and a bus-park control, inserts a guaranteed idle turnaround on every ownership change, and revokes a user grant held too long while PFL is waiting.
- Replaces the ad-hoc access flag in the system CPLD top level.

Parameters:
- TURN_CYC, 4, turnaround cycles with the bus parked on every ownership change; legal 1..15.
- HOLD_W, 20, width of the user-hold counter.
- USR_MAX_HOLD, 20'hFFFFF, user grant cycles before revocation when PFL is pending; legal 1..2^HOLD_W-1.

Ports:
- clkin_max_100  in  1  system clock, 100 MHz.
- sys_resetn  in  1  synchronous active-low reset.
- pfl_req  in  1  PFL requests the bus; level, held until done.
- usr_req  in  1  user flash controller requests the bus; level.
- grant_pfl  out  1  PFL owns the bus.
- grant_usr  out  1  user controller owns the bus.
- sel_pfl  out  1  mux select; 1 = PFL pins drive the flash.
- bus_park  out  1  1 = top level forces cen/oen/wen/advn high and fsm_d to Z.
- usr_timeout  out  1  one-cycle pulse when the user grant is revoked.
- owner  out  2  00 none, 01 PFL, 10 user, 11 turnaround.

Behaviour:
- Reset, and the state after any cycle with sys_resetn=0:
  - state IDLE; grant_pfl=0, grant_usr=0.
  - sel_pfl=1, bus_park=1, usr_timeout=0, owner=00.
  - last_owner=USR, so PFL wins the first tie.
  - turn_cnt=0, hold_cnt=0.
  - Reset mid-grant drops the grant the next edge with no turnaround.
- States: IDLE, SETUP, GNT_PFL, GNT_USR, DRAIN. All outputs are registered.
- IDLE:
  - bus_park=1, owner=00.
  - pfl_req only, or both with last_owner=USR: go to SETUP and set sel_pfl=1, target=PFL.
  - usr_req only, or both with last_owner=PFL: go to SETUP and set sel_pfl=0, target=USR.
  - Simultaneous requests therefore alternate round-robin.
- SETUP:
  - bus_park=1, owner=11; turn_cnt counts 0..TURN_CYC-1.
  - On the terminal count, enter GNT_target, assert the matching grant and set last_owner=target.
  - Latency from req sampled in IDLE to grant high is exactly TURN_CYC+1 cycles.
  - The requester deasserting req during SETUP aborts: go to DRAIN, no grant issued.
- GNT_PFL:
  - bus_park=0, owner=01, grant_pfl=1.
  - pfl_req=0 sampled: grant_pfl=0 next cycle, go to DRAIN.
  - No timeout applies to PFL.
- GNT_USR:
  - bus_park=0, owner=10, grant_usr=1.
  - hold_cnt increments each cycle and saturates at all-ones.
  - usr_req=0 sampled: grant_usr=0, go to DRAIN.
  - Revocation: if hold_cnt==USR_MAX_HOLD-1 and pfl_req=1 on the same cycle, then on the next edge grant_usr=0, usr_timeout=1 for one cycle, go to DRAIN.
  - If pfl_req is absent at the limit, no revocation. Revocation triggers on the first cycle after that where pfl_req=1.
  - usr_req dropping on the same cycle as the timeout condition counts as a normal release: usr_timeout stays 0.
- DRAIN:
  - bus_park=1, owner=11; grants are 0; turn_cnt counts TURN_CYC cycles, then go to IDLE.
  - sel_pfl holds its value through DRAIN.
  - hold_cnt clears on entry.
- Invariants:
  - Never grant_pfl & grant_usr.
  - Any grant implies bus_park=0.
  - sel_pfl changes only in the IDLE→SETUP transition.
- Counters are unsigned; turn_cnt is 4 bits and hold_cnt is HOLD_W bits, neither wraps.
- Requests that arrive in DRAIN are serviced only after IDLE, adding one extra cycle.

Decomposition:
- Package flash_arb_pkg holds:
  - state encoding localparams for IDLE, SETUP, GNT_PFL, GNT_USR, DRAIN;
  - owner codes OWN_NONE=2'b00, OWN_PFL=2'b01, OWN_USR=2'b10, OWN_TURN=2'b11.
- One natural sub-module: flash_arb_turn_timer, a loadable down-counter with a done pulse, reused by SETUP and DRAIN.
- The hold counter stays inline.

Test Plan:
- Reset release, then pfl_req=1 at cycle 0 with TURN_CYC=4 → grant_pfl=1 at cycle 5, sel_pfl=1, bus_park 1→0 on that same cycle, owner 11→01.
- pfl_req=usr_req=1 together after reset → PFL granted first. PFL releases, then after a 4-cycle DRAIN plus 1 IDLE plus 4 SETUP → grant_usr=1 with sel_pfl=0. A second tie → PFL wins again.
- USR_MAX_HOLD=16, usr granted, pfl_req rises at hold cycle 5 → at hold cycle 16 grant_usr=0, usr_timeout one pulse, then DRAIN 4 cycles, SETUP 4 cycles, then grant_pfl=1.
- USR_MAX_HOLD=16, usr holds 40 cycles with no pfl_req → no timeout. pfl_req raised at cycle 40 → revocation on the next edge.
- usr_req drops in the 2nd SETUP cycle → no grant ever asserted, DRAIN entered, owner returns to 00 after 4 cycles.
- sys_resetn=0 for 1 cycle during GNT_USR → next edge: grants 0, sel_pfl=1, bus_park=1, owner=00, usr_timeout=0.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared encodings for the flash bus arbiter: FSM states, owner codes and
// requester identities.
package flash_arb_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_GNT_PFL = 3'd2;
  localparam state_t ST_GNT_USR = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_PFL  = 2'b01;
  localparam logic [1:0] OWN_USR  = 2'b10;
  localparam logic [1:0] OWN_TURN = 2'b11;

  typedef enum logic {
    SIDE_PFL = 1'b0,
    SIDE_USR = 1'b1
  } side_t;

  // Owner code reported for the state the FSM is about to occupy.
  function automatic logic [1:0] owner_of(input state_t st);
    logic [1:0] code;
    case (st)
      ST_IDLE:    code = OWN_NONE;
      ST_GNT_PFL: code = OWN_PFL;
      ST_GNT_USR: code = OWN_USR;
      default:    code = OWN_TURN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/flash_arb_turn_timer.sv
// Loadable down-counter for the bus-parked turnaround windows; done is high
// for exactly one cycle when the loaded count has run out.
module flash_arb_turn_timer (
  input  logic       clkin_max_100,
  input  logic       sys_resetn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt_reg;
  logic       run_reg;

  always_ff @(posedge clkin_max_100) begin
    if (!sys_resetn) begin
      cnt_reg <= 4'd0;
      run_reg <= 1'b0;
    end else if (load) begin
      cnt_reg <= load_val;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (cnt_reg == 4'd0) begin
        run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  assign done = run_reg && (cnt_reg == 4'd0);

endmodule

// File: rtl/flash_bus_arbiter.sv
// Arbitrates the shared parallel-flash bus between the PFL engine and the user
// controller, parking the bus for a fixed turnaround on every ownership change.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int                TURN_CYC     = 4,
  parameter int                HOLD_W       = 20,
  parameter logic [HOLD_W-1:0] USR_MAX_HOLD = 20'hFFFFF
) (
  input  logic       clkin_max_100,
  input  logic       sys_resetn,
  input  logic       pfl_req,
  input  logic       usr_req,
  output logic       grant_pfl,
  output logic       grant_usr,
  output logic       sel_pfl,
  output logic       bus_park,
  output logic       usr_timeout,
  output logic [1:0] owner
);

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);

  state_t            state_reg, state_next;
  side_t             target_reg, target_next;
  side_t             last_owner_reg, last_owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic       grant_pfl_reg, grant_pfl_next;
  logic       grant_usr_reg, grant_usr_next;
  logic       sel_pfl_reg, sel_pfl_next;
  logic       bus_park_reg, bus_park_next;
  logic       usr_timeout_reg, usr_timeout_next;
  logic [1:0] owner_reg, owner_next;

  logic timer_load;
  logic timer_done;
  logic revoke;
  logic tgt_req;

  flash_arb_turn_timer u_turn_timer (
    .clkin_max_100 (clkin_max_100),
    .sys_resetn    (sys_resetn),
    .load          (timer_load),
    .load_val      (TURN_LOAD),
    .done          (timer_done)
  );

  assign tgt_req = (target_reg == SIDE_PFL) ? pfl_req : usr_req;

  always_ff @(posedge clkin_max_100) begin
    if (!sys_resetn) begin
      state_reg       <= ST_IDLE;
      target_reg      <= SIDE_PFL;
      last_owner_reg  <= SIDE_USR;
      hold_cnt_reg    <= '0;
      grant_pfl_reg   <= 1'b0;
      grant_usr_reg   <= 1'b0;
      sel_pfl_reg     <= 1'b1;
      bus_park_reg    <= 1'b1;
      usr_timeout_reg <= 1'b0;
      owner_reg       <= OWN_NONE;
    end else begin
      state_reg       <= state_next;
      target_reg      <= target_next;
      last_owner_reg  <= last_owner_next;
      hold_cnt_reg    <= hold_cnt_next;
      grant_pfl_reg   <= grant_pfl_next;
      grant_usr_reg   <= grant_usr_next;
      sel_pfl_reg     <= sel_pfl_next;
      bus_park_reg    <= bus_park_next;
      usr_timeout_reg <= usr_timeout_next;
      owner_reg       <= owner_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    timer_load  = 1'b0;
    revoke      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // On a tie the side that did not own the bus last goes first.
        if (pfl_req && (!usr_req || last_owner_reg == SIDE_USR)) begin
          state_next  = ST_SETUP;
          target_next = SIDE_PFL;
          timer_load  = 1'b1;
        end else if (usr_req) begin
          state_next  = ST_SETUP;
          target_next = SIDE_USR;
          timer_load  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!tgt_req) begin
          state_next = ST_DRAIN;
          timer_load = 1'b1;
        end else if (timer_done) begin
          state_next = (target_reg == SIDE_PFL) ? ST_GNT_PFL : ST_GNT_USR;
        end
      end
      ST_GNT_PFL: begin
        if (!pfl_req) begin
          state_next = ST_DRAIN;
          timer_load = 1'b1;
        end
      end
      ST_GNT_USR: begin
        // A voluntary release wins over revocation on the same cycle.
        if (!usr_req) begin
          state_next = ST_DRAIN;
          timer_load = 1'b1;
        end else if (pfl_req && (hold_cnt_reg >= USR_MAX_HOLD - 1'b1)) begin
          state_next = ST_DRAIN;
          timer_load = 1'b1;
          revoke     = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (timer_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_pfl_next   = (state_next == ST_GNT_PFL);
    grant_usr_next   = (state_next == ST_GNT_USR);
    bus_park_next    = !((state_next == ST_GNT_PFL) || (state_next == ST_GNT_USR));
    owner_next       = owner_of(state_next);
    usr_timeout_next = revoke;

    sel_pfl_next = sel_pfl_reg;
    if (state_reg == ST_IDLE && state_next == ST_SETUP) begin
      sel_pfl_next = (target_next == SIDE_PFL);
    end

    last_owner_next = last_owner_reg;
    if (state_reg == ST_SETUP && state_next == ST_GNT_PFL) begin
      last_owner_next = SIDE_PFL;
    end else if (state_reg == ST_SETUP && state_next == ST_GNT_USR) begin
      last_owner_next = SIDE_USR;
    end

    hold_cnt_next = hold_cnt_reg;
    if (state_reg == ST_GNT_USR && hold_cnt_reg != {HOLD_W{1'b1}}) begin
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end
    if (state_next == ST_DRAIN && state_reg != ST_DRAIN) begin
      hold_cnt_next = '0;
    end
  end

  assign grant_pfl   = grant_pfl_reg;
  assign grant_usr   = grant_usr_reg;
  assign sel_pfl     = sel_pfl_reg;
  assign bus_park    = bus_park_reg;
  assign usr_timeout = usr_timeout_reg;
  assign owner       = owner_reg;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Cycle-by-cycle vector table for the flash bus arbiter, plus latency
// sequences and an always-on invariant monitor.
module tb_flash_bus_arbiter;

  logic       clkin_max_100 = 1'b0;
  logic       sys_resetn;
  logic       pfl_req;
  logic       usr_req;
  logic       grant_pfl;
  logic       grant_usr;
  logic       sel_pfl;
  logic       bus_park;
  logic       usr_timeout;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  always #5 clkin_max_100 = ~clkin_max_100;

  flash_bus_arbiter #(
    .TURN_CYC     (4),
    .HOLD_W       (20),
    .USR_MAX_HOLD (20'd16)
  ) dut (
    .clkin_max_100 (clkin_max_100),
    .sys_resetn    (sys_resetn),
    .pfl_req       (pfl_req),
    .usr_req       (usr_req),
    .grant_pfl     (grant_pfl),
    .grant_usr     (grant_usr),
    .sel_pfl       (sel_pfl),
    .bus_park      (bus_park),
    .usr_timeout   (usr_timeout),
    .owner         (owner)
  );

  // Expected output word: {grant_pfl, grant_usr, sel_pfl, bus_park, usr_timeout, owner}
  typedef struct {
    logic       rstn;
    logic       pfl;
    logic       usr;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] E_GP = 7'b1010001;
  localparam logic [6:0] E_GU = 7'b0100010;

  function automatic logic [6:0] e_idle(input logic s);
    return {2'b00, s, 1'b1, 1'b0, 2'b00};
  endfunction

  function automatic logic [6:0] e_setup(input logic s);
    return {2'b00, s, 1'b1, 1'b0, 2'b11};
  endfunction

  function automatic logic [6:0] e_drain(input logic s, input logic to);
    return {2'b00, s, 1'b1, to, 2'b11};
  endfunction

  task automatic add(input int n, input logic r, input logic p, input logic u,
                     input logic [6:0] e);
    vec_t v;
    v.rstn = r;
    v.pfl  = p;
    v.usr  = u;
    v.exp  = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("%s ok value=%0d", name, act);
    end
  endtask

  logic       mon_en = 1'b0;
  logic       prev_sel;
  logic [1:0] prev_owner;

  always @(negedge clkin_max_100) begin
    if (mon_en) begin
      checks++;
      if (grant_pfl && grant_usr) begin
        errors++;
        $display("FAIL inv_two_grants actual=11 required=not both");
      end
      checks++;
      if ((grant_pfl || grant_usr) && bus_park) begin
        errors++;
        $display("FAIL inv_grant_parked actual bus_park=1 required=0");
      end
      if (sel_pfl != prev_sel && owner != 2'b00) begin
        checks++;
        if (!(prev_owner == 2'b00 && owner == 2'b11)) begin
          errors++;
          $display("FAIL inv_sel_change actual owner %0b->%0b required 00->11",
                   prev_owner, owner);
        end
      end
      prev_sel   = sel_pfl;
      prev_owner = owner;
    end
  end

  initial begin
    logic [6:0] act;
    int         lat;
    logic       pre_park;
    logic [1:0] pre_owner;

    sys_resetn = 1'b0;
    pfl_req    = 1'b0;
    usr_req    = 1'b0;

    // Reset, then PFL alone: 4 SETUP cycles, grant, release, 4 DRAIN cycles.
    add(1, 0, 0, 0, e_idle(1));
    add(4, 1, 1, 0, e_setup(1));
    add(2, 1, 1, 0, E_GP);
    add(4, 1, 0, 0, e_drain(1, 0));
    add(1, 1, 0, 0, e_idle(1));
    // Tie after reset: PFL first, then user, then PFL wins the next tie.
    add(1, 0, 0, 0, e_idle(1));
    add(4, 1, 1, 1, e_setup(1));
    add(1, 1, 1, 1, E_GP);
    add(4, 1, 0, 1, e_drain(1, 0));
    add(1, 1, 0, 1, e_idle(1));
    add(4, 1, 0, 1, e_setup(0));
    add(1, 1, 0, 1, E_GU);
    add(4, 1, 0, 0, e_drain(0, 0));
    add(1, 1, 1, 1, e_idle(0));
    add(4, 1, 1, 1, e_setup(1));
    add(1, 1, 1, 1, E_GP);
    add(4, 1, 0, 0, e_drain(1, 0));
    add(1, 1, 0, 0, e_idle(1));
    // User granted, PFL raised at hold cycle 5, revoked at hold cycle 16.
    add(4, 1, 0, 1, e_setup(0));
    add(1, 1, 0, 1, E_GU);
    add(5, 1, 0, 1, E_GU);
    add(10, 1, 1, 1, E_GU);
    add(1, 1, 1, 1, e_drain(0, 1));
    add(3, 1, 1, 1, e_drain(0, 0));
    add(1, 1, 1, 1, e_idle(0));
    add(4, 1, 1, 1, e_setup(1));
    add(1, 1, 1, 1, E_GP);
    add(4, 1, 0, 0, e_drain(1, 0));
    add(1, 1, 0, 0, e_idle(1));
    // User holds 40 cycles alone, then PFL asks: revoked on the next edge.
    add(4, 1, 0, 1, e_setup(0));
    add(1, 1, 0, 1, E_GU);
    add(40, 1, 0, 1, E_GU);
    add(1, 1, 1, 1, e_drain(0, 1));
    add(3, 1, 0, 0, e_drain(0, 0));
    add(1, 1, 0, 0, e_idle(0));
    // User drops its request in the second SETUP cycle: no grant.
    add(2, 1, 0, 1, e_setup(0));
    add(1, 1, 0, 0, e_drain(0, 0));
    add(3, 1, 0, 0, e_drain(0, 0));
    add(1, 1, 0, 0, e_idle(0));
    // User releases on the very cycle the timeout would fire: no pulse.
    add(4, 1, 0, 1, e_setup(0));
    add(1, 1, 0, 1, E_GU);
    add(2, 1, 0, 1, E_GU);
    add(13, 1, 1, 1, E_GU);
    add(1, 1, 1, 0, e_drain(0, 0));
    add(3, 1, 1, 0, e_drain(0, 0));
    add(1, 1, 1, 0, e_idle(0));
    add(4, 1, 1, 0, e_setup(1));
    add(1, 1, 1, 0, E_GP);
    add(4, 1, 0, 0, e_drain(1, 0));
    add(1, 1, 0, 0, e_idle(1));
    // Reset pulse while the user holds the bus.
    add(4, 1, 0, 1, e_setup(0));
    add(2, 1, 0, 1, E_GU);
    add(1, 0, 0, 1, e_idle(1));
    add(1, 1, 0, 0, e_idle(1));

    foreach (vecs[i]) begin
      sys_resetn = vecs[i].rstn;
      pfl_req    = vecs[i].pfl;
      usr_req    = vecs[i].usr;
      @(posedge clkin_max_100);
      #1;
      act = {grant_pfl, grant_usr, sel_pfl, bus_park, usr_timeout, owner};
      checks++;
      if (act !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d actual=%07b required=%07b", i, act, vecs[i].exp);
      end else begin
        $display("vec %0d rstn=%0b pfl=%0b usr=%0b out=%07b ok",
                 i, vecs[i].rstn, vecs[i].pfl, vecs[i].usr, act);
      end
      if (i == 0) begin
        prev_sel   = sel_pfl;
        prev_owner = owner;
        mon_en     = 1'b1;
      end
    end

    // PFL request to grant latency, counted from the IDLE sampling edge.
    sys_resetn = 1'b0;
    pfl_req    = 1'b0;
    usr_req    = 1'b0;
    @(posedge clkin_max_100);
    #1;
    sys_resetn = 1'b1;
    pfl_req    = 1'b1;
    lat        = 0;
    pre_park   = bus_park;
    pre_owner  = owner;
    while (!grant_pfl && lat < 20) begin
      pre_park  = bus_park;
      pre_owner = owner;
      @(posedge clkin_max_100);
      #1;
      lat++;
    end
    check("pfl_latency", lat, 5);
    check("pfl_sel", int'(sel_pfl), 1);
    check("pfl_park", int'(bus_park), 0);
    check("pfl_owner", int'(owner), 1);
    check("pre_grant_park", int'(pre_park), 1);
    check("pre_grant_owner", int'(pre_owner), 3);

    // Hand-over to a request raised at release: DRAIN + IDLE + SETUP.
    pfl_req = 1'b0;
    usr_req = 1'b1;
    lat     = 0;
    while (!grant_usr && lat < 30) begin
      @(posedge clkin_max_100);
      #1;
      lat++;
    end
    check("usr_handover_latency", lat, 10);
    check("usr_sel", int'(sel_pfl), 0);
    check("usr_owner", int'(owner), 2);

    usr_req = 1'b0;
    repeat (6) @(posedge clkin_max_100);
    #1;
    check("final_owner", int'(owner), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
